// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES round sequencer
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} seq_state_t;

  typedef logic [127:0] block_t;
  typedef logic [3:0]   round_idx_t;

endpackage

// File: rtl/aes_round_key_store.sv
// rtl/aes_round_key_store.sv - 11-entry round-key register file, one write and one read port
// KEY_CACHE_EN adds a valid bit and a compare of the incoming key against the cached rk[0].
module aes_round_key_store
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wrEn,
  input  logic [3:0]   wrIdx,
  input  logic [127:0] wrData,
  input  logic [3:0]   rdIdx,
  output logic [127:0] rdData,
  output logic [127:0] lastKey,
  input  logic [127:0] cmpKey,
  output logic         keyHit
);

  block_t keys [AES_NUM_ROUNDS+1];

  always_ff @(posedge clk) begin
    if (wrEn) keys[wrIdx] <= wrData;
  end

  assign rdData  = keys[rdIdx];
  // rk[10] gets its own tap so a cached decrypt can whiten and fetch rk[9] in one cycle
  assign lastKey = keys[AES_NUM_ROUNDS];

`ifdef KEY_CACHE_EN
  logic cacheValid;

  // A new rk[0] invalidates the set until the final round key lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cacheValid <= 1'b0;
    end else if (wrEn && wrIdx == 4'd0) begin
      cacheValid <= 1'b0;
    end else if (wrEn && wrIdx == 4'(AES_NUM_ROUNDS)) begin
      cacheValid <= 1'b1;
    end
  end

  assign keyHit = cacheValid && (cmpKey == keys[0]);
`else
  logic [128:0] unusedInputs;
  assign unusedInputs = {rst_n, cmpKey};
  assign keyHit       = 1'b0;
`endif

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - drives an external AES-128 round/key-expansion unit one step per cycle
// Optional KEY_CACHE_EN: reuse stored round keys when the same key arrives again.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_block,
  input  logic         in_encrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [127:0] aes_a,
  output logic [127:0] aes_b,
  output logic         aes_key_assist,
  output logic         aes_final_round,
  output logic         aes_encryption,
  input  logic [127:0] aes_result
);

  localparam round_idx_t LastRound = round_idx_t'(NUM_ROUNDS);

  seq_state_t fsm, fsmNext;
  round_idx_t r, rNext, rInc, rDec;
  logic       encDir, encDirNext;
  logic       skipExp, skipExpNext;
  block_t     dataReg, dataNext;
  block_t     aesANext, aesBNext;
  logic       keyAssistNext, finalNext, encNext;
  logic       wrEn;
  round_idx_t wrIdx, rdIdx;
  block_t     wrData, rdData, lastKey;
  logic       keyHit;

  aes_round_key_store u_keyStore (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrEn    (wrEn),
    .wrIdx   (wrIdx),
    .wrData  (wrData),
    .rdIdx   (rdIdx),
    .rdData  (rdData),
    .lastKey (lastKey),
    .cmpKey  (in_key),
    .keyHit  (keyHit)
  );

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign out_block = (fsm == DONE) ? dataReg : '0;
  assign rInc      = r + 4'd1;
  assign rDec      = r - 4'd1;

  // aes_* are registered, so each branch prepares the unit inputs for the state being entered
  always_comb begin
    fsmNext       = fsm;
    rNext         = r;
    encDirNext    = encDir;
    skipExpNext   = skipExp;
    dataNext      = dataReg;
    aesANext      = '0;
    aesBNext      = '0;
    keyAssistNext = 1'b0;
    finalNext     = 1'b0;
    encNext       = 1'b0;
    wrEn          = 1'b0;
    wrIdx         = r;
    wrData        = aes_result;
    rdIdx         = '0;
    case (fsm)
      IDLE: begin
        if (in_valid) begin
          encDirNext  = in_encrypt;
          skipExpNext = keyHit;
          fsmNext     = keyHit ? ROUND : EXPAND;
          if (keyHit && in_encrypt) begin
            rNext    = 4'd1;
            rdIdx    = 4'd1;
            dataNext = in_block ^ in_key;
            aesANext = dataNext;
            aesBNext = rdData;
            encNext  = 1'b1;
          end else if (keyHit) begin
            rNext    = LastRound - 4'd1;
            rdIdx    = LastRound - 4'd1;
            dataNext = in_block ^ lastKey;
            aesANext = dataNext;
            aesBNext = rdData;
          end else begin
            wrEn          = 1'b1;
            wrIdx         = 4'd0;
            wrData        = in_key;
            rNext         = 4'd1;
            dataNext      = in_encrypt ? (in_block ^ in_key) : in_block;
            aesANext      = in_key;
            aesBNext      = 128'd1;
            keyAssistNext = 1'b1;
          end
        end
      end
      EXPAND: begin
        wrEn = 1'b1;
        if (encDir) begin
          fsmNext   = ROUND;
          aesANext  = dataReg;
          aesBNext  = aes_result;
          encNext   = 1'b1;
          finalNext = (r == LastRound);
        end else if (r != LastRound) begin
          rNext         = rInc;
          aesANext      = aes_result;
          aesBNext      = {124'd0, rInc};
          keyAssistNext = 1'b1;
        end else begin
          // rk[10] is still on aes_result this cycle, so whiten from there
          fsmNext  = ROUND;
          dataNext = dataReg ^ aes_result;
          rNext    = LastRound - 4'd1;
          rdIdx    = LastRound - 4'd1;
          aesANext = dataNext;
          aesBNext = rdData;
        end
      end
      ROUND: begin
        dataNext = aes_result;
        if (encDir) begin
          if (r == LastRound) begin
            fsmNext = DONE;
          end else if (skipExp) begin
            rNext     = rInc;
            rdIdx     = rInc;
            aesANext  = aes_result;
            aesBNext  = rdData;
            encNext   = 1'b1;
            finalNext = (rInc == LastRound);
          end else begin
            fsmNext       = EXPAND;
            rNext         = rInc;
            aesANext      = aes_b;
            aesBNext      = {124'd0, rInc};
            keyAssistNext = 1'b1;
          end
        end else begin
          if (r == 4'd0) begin
            fsmNext = DONE;
          end else begin
            rNext     = rDec;
            rdIdx     = rDec;
            aesANext  = aes_result;
            aesBNext  = rdData;
            finalNext = (rDec == 4'd0);
          end
        end
      end
      DONE: begin
        if (out_ready) fsmNext = IDLE;
      end
      default: fsmNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm             <= IDLE;
      r               <= '0;
      encDir          <= 1'b0;
      skipExp         <= 1'b0;
      dataReg         <= '0;
      aes_a           <= '0;
      aes_b           <= '0;
      aes_key_assist  <= 1'b0;
      aes_final_round <= 1'b0;
      aes_encryption  <= 1'b0;
    end else begin
      fsm             <= fsmNext;
      r               <= rNext;
      encDir          <= encDirNext;
      skipExp         <= skipExpNext;
      dataReg         <= dataNext;
      aes_a           <= aesANext;
      aes_b           <= aesBNext;
      aes_key_assist  <= keyAssistNext;
      aes_final_round <= finalNext;
      aes_encryption  <= encNext;
    end
  end

endmodule
